bcd_timer: RTL and testbench

Minutes:seconds BCD timer driven by the toggling output of the clock divider. The divided clock is treated as a data input: it is synchronised into `clk`, and each rising edge is counted as one second while the timer runs. The block sits directly downstream of the divider and feeds the display/LED driver. Start, stop and clear controls use a three-state machine.

---
 rtl/bcd_timer_pkg.sv | 33 +++
 rtl/bcd_timer_tick_sync.sv | 26 ++
 rtl/bcd_timer.sv | 148 ++++++++++++++
 tb/tb_bcd_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the minutes:seconds BCD timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    typedef struct packed {
        logic carry;
        bcd_t digit;
    } bcd_inc_t;

    // Wraps to 0 with carry once the digit reaches its top value.
    function automatic bcd_inc_t bcd_inc(input bcd_t d, input bcd_t top);
        bcd_inc_t r;
        if (d >= top) begin
            r.carry = 1'b1;
            r.digit = 4'd0;
        end else begin
            r.carry = 1'b0;
            r.digit = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_timer_tick_sync.sv
// Synchroniser for the divided-clock toggle plus rising-edge detector.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic tick_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/bcd_timer.sv
// Minutes:seconds BCD timer counting rising edges of the divided clock.
// Optional alarm compare enabled by defining BCD_TIMER_ALARM_EN.
//
//   state | meaning
//   IDLE  | count held at 00:00, waiting for start
//   RUN   | each synchronised tick edge advances the count
//   PAUSE | count frozen, start resumes, clear returns to IDLE
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] alarm_min,
    input  logic [7:0] alarm_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       sec_pulse,
    output logic       rollover,
    output logic       alarm
);

    localparam bcd_t       MIN_TENS_TOP  = bcd_t'(MAX_MIN / 10);
    localparam bcd_t       MIN_UNITS_TOP = bcd_t'(MAX_MIN % 10);
    localparam logic [7:0] MIN_TOP       = {MIN_TENS_TOP, MIN_UNITS_TOP};

    state_t     state_q;
    logic [7:0] min_q, sec_q;
    logic [7:0] min_d, sec_d;
    logic       running_q, sec_pulse_q, rollover_q, alarm_q;
    logic       wrap_d, alarm_hit;
    logic       tick_edge;
    bcd_inc_t   sec_u, sec_t, min_u;

    tick_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .tick_edge (tick_edge)
    );

    always_comb begin
        sec_u  = bcd_inc(sec_q[3:0], DIGIT_MAX);
        sec_t  = bcd_inc(sec_q[7:4], SEC_TENS_MAX);
        min_u  = bcd_inc(min_q[3:0], DIGIT_MAX);
        sec_d  = {sec_q[7:4], sec_u.digit};
        min_d  = min_q;
        wrap_d = 1'b0;
        if (sec_u.carry) begin
            sec_d = {sec_t.digit, 4'd0};
            if (sec_t.carry) begin
                if (min_q == MIN_TOP) begin
                    min_d  = 8'h00;
                    wrap_d = 1'b1;
                end else if (min_u.carry) begin
                    min_d = {min_q[7:4] + 4'd1, 4'd0};
                end else begin
                    min_d = {min_q[7:4], min_u.digit};
                end
            end
        end
    end

`ifdef BCD_TIMER_ALARM_EN
    assign alarm_hit = ({min_d, sec_d} == {alarm_min, alarm_sec});
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_min, alarm_sec};
    assign alarm_hit    = 1'b0;
`endif

    // Clear wins over everything; in RUN a coincident edge is counted before stop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            running_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            rollover_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            sec_pulse_q <= 1'b0;
            rollover_q  <= 1'b0;
            alarm_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!clear && start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                        min_q     <= 8'h00;
                        sec_q     <= 8'h00;
                    end else begin
                        if (tick_edge) begin
                            min_q       <= min_d;
                            sec_q       <= sec_d;
                            sec_pulse_q <= 1'b1;
                            rollover_q  <= wrap_d;
                            alarm_q     <= alarm_hit;
                        end
                        if (stop) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (clear) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                        min_q     <= 8'h00;
                        sec_q     <= 8'h00;
                    end else if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign running   = running_q;
    assign sec_pulse = sec_pulse_q;
    assign rollover  = rollover_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench for bcd_timer: a seconds-based reference model predicts each
// counted second; a monitor checks every sec_pulse against the queued prediction.
module tb_bcd_timer;

    localparam int S       = 2;
    localparam int MAXM    = 2;
    localparam int PERIOD  = (MAXM + 1) * 60;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
`ifdef BCD_TIMER_ALARM_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, tick_in, start, stop, clear;
    logic [7:0] alarm_min, alarm_sec;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, sec_pulse, rollover, alarm;

    typedef struct {
        logic [7:0] min;
        logic [7:0] sec;
        logic       roll;
        logic       alm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_secs   = 0;
    int   m_state  = M_IDLE;
    bit   done     = 1'b0;

    bcd_timer #(
        .SYNC_STAGES (S),
        .MAX_MIN     (MAXM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .alarm_min (alarm_min),
        .alarm_sec (alarm_sec),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .running   (running),
        .sec_pulse (sec_pulse),
        .rollover  (rollover),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_count(input string name);
        check(name, {min_bcd, sec_bcd}, {to_bcd(m_secs / 60), to_bcd(m_secs % 60)});
    endtask

    // One full tick_in period; optional commands land in the cycle the edge is counted.
    task automatic tick(input logic st, input logic sp, input logic cl);
        exp_t e;
        tick_in = 1'b1;
        repeat (S) @(negedge clk);
        check_count("pre_update");
        if (cl) begin
            m_state = M_IDLE;
            m_secs  = 0;
        end else if (m_state == M_RUN) begin
            m_secs = (m_secs + 1) % PERIOD;
            e.min  = to_bcd(m_secs / 60);
            e.sec  = to_bcd(m_secs % 60);
            e.roll = (m_secs == 0);
            e.alm  = ALM_EN && ({e.min, e.sec} == {alarm_min, alarm_sec});
            exp_q.push_back(e);
            if (sp) m_state = M_PAUSE;
        end else if (st) begin
            m_state = M_RUN;
        end
        start = st;
        stop  = sp;
        clear = cl;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        check_count("post_update");
        check("running", running, m_state == M_RUN);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tick_in = 1'b0;
        repeat (S + 1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic cmd(input logic st, input logic sp, input logic cl);
        if (cl) begin
            m_state = M_IDLE;
            m_secs  = 0;
        end else if (sp && m_state == M_RUN) begin
            m_state = M_PAUSE;
        end else if (st && m_state != M_RUN) begin
            m_state = M_RUN;
        end
        start = st;
        stop  = sp;
        clear = cl;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        check("cmd_running", running, m_state == M_RUN);
        check_count("cmd_count");
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            tick_in = ~tick_in;
            @(negedge clk);
        end
        m_state = M_IDLE;
        m_secs  = 0;
        check("rst_outputs", {min_bcd, sec_bcd, running, sec_pulse, rollover, alarm}, 0);
        rst_n   = 1'b1;
        tick_in = 1'b0;
        repeat (S + 2) @(negedge clk);
        check("rst_hold", {min_bcd, sec_bcd, running, sec_pulse}, 0);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (sec_pulse) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got sec_pulse=1 expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_min", min_bcd, e.min);
                    check("pulse_sec", sec_bcd, e.sec);
                    check("pulse_rollover", rollover, e.roll);
                    check("pulse_alarm", alarm, e.alm);
                end
            end else begin
                check("stray_flags", {rollover, alarm}, 2'b00);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        tick_in   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        alarm_min = 8'h00;
        alarm_sec = 8'h05;
        @(negedge clk);
        do_reset(2);

        // Basic count and latency.
        cmd(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("basic_sec3", sec_bcd, 8'h03);

        // Seconds carry into minutes.
        while (m_secs != 58) tick(1'b0, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        check("carry_0100", {min_bcd, sec_bcd}, 16'h0100);

        // Full wrap at MAX_MIN:59.
        while (m_secs != PERIOD - 1) tick(1'b0, 1'b0, 1'b0);
        check("pre_wrap", {min_bcd, sec_bcd}, 16'h0259);
        tick(1'b0, 1'b0, 1'b0);
        check("wrap_0000", {min_bcd, sec_bcd}, 16'h0000);

        // Command priority with all three at once.
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        cmd(1'b1, 1'b1, 1'b1);
        check("prio_idle", {running, min_bcd, sec_bcd}, 17'h0);

        // Stop coinciding with an edge, then edges while paused.
        cmd(1'b1, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("stop_edge", {running, sec_bcd}, {1'b0, 8'h03});
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("pause_hold", sec_bcd, 8'h03);

        // Start coinciding with an edge is not counted; clear with an edge drops it.
        tick(1'b1, 1'b0, 1'b0);
        check("start_edge", {running, sec_bcd}, {1'b1, 8'h03});
        tick(1'b0, 1'b0, 1'b1);
        check("clear_edge", {running, min_bcd, sec_bcd}, 17'h0);

        // Reset in the middle of a run.
        cmd(1'b1, 1'b0, 1'b0);
        while (m_secs != 37) tick(1'b0, 1'b0, 1'b0);
        do_reset(1);
        cmd(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("after_reset", {min_bcd, sec_bcd}, 16'h0001);

        // Randomised mix of edges and commands.
        for (int i = 0; i < 300; i++) begin
            logic st, sp, cl;
            st = ($urandom_range(0, 2) == 0);
            sp = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) < 8) tick(st, sp, cl);
            else cmd(st, sp, cl);
        end

        repeat (S + 4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
